mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, load/store data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, byte address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum WAIT cycles before an access fault.
REQ-004 SHALL have one clock and an asynchronous active-low reset: i_clk  in  1  clock, rising edge; i_arstn  in  1  reset, async, active-low.
REQ-005 SHALL have i_mem_access  in  1  memory instruction present in the execute/memory register.
REQ-006 SHALL have i_mem_we  in  1  store (1) or load (0).
REQ-007 SHALL have i_func3  in  3  size in [1:0] (0=B, 1=H, 2=W, 3=D); [2]=1 means zero-extend.
REQ-008 SHALL have i_addr  in  ADDR_WIDTH  byte address (ALU result).
REQ-009 SHALL have i_write_data  in  DATA_WIDTH  store data, LSB-aligned.
REQ-010 SHALL have o_stall_mem  out  1  holds the execute/memory register.
REQ-011 SHALL have o_req_valid/i_req_ready  out/in  1  request handshake.
REQ-012 SHALL have o_req_addr  out  ADDR_WIDTH  8-byte-aligned address; o_req_we  out  1; o_req_be  out  8  byte enables; o_req_wdata  out  DATA_WIDTH  lane-shifted data.
REQ-013 SHALL have i_rsp_valid  in  1; i_rsp_rdata  in  DATA_WIDTH; i_rsp_err  in  1  response handshake; no ready, always accepted.
REQ-014 SHALL have o_done  out  1; o_load_data  out  DATA_WIDTH; o_fault  out  1; o_cause  out  4.

Function
REQ-015 SHALL implement the FSM states IDLE, REQ, WAIT and DONE.
REQ-016 In IDLE with i_mem_access=1, SHALL latch addr, func3, we and data, assert o_stall_mem combinationally, and go to REQ, or to DONE with fault if misaligned.
REQ-017 In REQ, SHALL assert o_req_valid with stable payload until i_req_ready=1, then go to WAIT; o_stall_mem=1.
REQ-018 In WAIT, on i_rsp_valid=1 SHALL capture data and go to DONE; o_stall_mem=1; the response is not accepted in the same cycle as the request.
REQ-019 WAIT counter SHALL clear on entry; reaching TIMEOUT_CYCLES without a response SHALL fault and go to DONE.
REQ-020 In DONE, SHALL drive o_done=1 and o_stall_mem=0 for exactly one cycle, then go to IDLE.
REQ-021 o_req_be SHALL equal the size mask (0x01/0x03/0x0F/0xFF) shifted left by addr[2:0]; o_req_wdata SHALL equal the data shifted left by 8*addr[2:0].
REQ-022 o_load_data SHALL equal rdata shifted right by 8*addr[2:0], truncated to the size, then sign- or zero-extended per func3[2]; stores SHALL give 0.
REQ-023 Faults SHALL set o_fault=1 in DONE with o_cause: 4 load misaligned, 5 load access fault, 6 store misaligned, 7 store access fault.
REQ-024 A fault SHALL force o_load_data=0; i_rsp_err=1 SHALL be an access fault.
REQ-025 i_rsp_valid outside WAIT SHALL be ignored.

Reset
REQ-026 Assertion of i_arstn=0 SHALL immediately force state IDLE, counter 0, and all registered outputs 0, including mid-REQ and mid-WAIT.
REQ-027 A request aborted by reset SHALL NOT be reissued.

Configuration
REQ-028 With MEM_ACCESS_MISALIGN_TRAP_EN defined, SHALL detect misalignment as addr not a multiple of the size and fault without a request.
REQ-029 Without MEM_ACCESS_MISALIGN_TRAP_EN, SHALL never raise causes 4 or 6 and SHALL issue the access with byte enables truncated to 8 bits, dropping bytes past the doubleword.

Structure
REQ-030 Package mem_access_pkg SHALL hold the state enum, size encodings, cause constants and the be-mask function.
REQ-031 Load extraction/extension SHALL be sub-module load_align (combinational).

Verification
REQ-032 LW addr=0x1004, ready at once, rdata=0x8000_0001_0000_0000 after 2 cycles -> be 0xF0, load_data=0xFFFF_FFFF_8000_0001, stall high 4 cycles.
REQ-033 LBU addr=0x1007, rdata[63:56]=0xAB -> be 0x80, load_data=0xAB.
REQ-034 SH addr=0x2002, data=0x1234, ready delayed 3 cycles -> req payload stable, be 0x0C, wdata[31:16]=0x1234.
REQ-035 SD addr=0x3004 (TRAP_EN) -> no o_req_valid, o_fault=1, cause 6; without TRAP_EN -> request issued.
REQ-036 LD with no response for TIMEOUT_CYCLES -> fault cause 5; i_rsp_err=1 on a store -> cause 7.
REQ-037 Reset asserted in WAIT -> IDLE, all outputs 0 asynchronously; a late i_rsp_valid is ignored.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store memory access unit:
// FSM states, access-size encodings, fault cause codes and byte-enable masks.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } mem_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_ACCESS    = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_STORE_ACCESS   = 4'd7;

    // Byte-lane mask of an access of the given size, before lane shifting.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            SIZE_B:  mask = 8'h01;
            SIZE_H:  mask = 8'h03;
            SIZE_W:  mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] mask;
        case (size)
            SIZE_B:  mask = 3'b000;
            SIZE_H:  mask = 3'b001;
            SIZE_W:  mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bus between the memory access unit (master) and the
// data memory (slave). Signal names are seen from the master side.
interface mem_access_unit_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    logic                  o_req_valid;
    logic                  i_req_ready;
    logic [ADDR_WIDTH-1:0] o_req_addr;
    logic                  o_req_we;
    logic [7:0]            o_req_be;
    logic [DATA_WIDTH-1:0] o_req_wdata;
    logic                  i_rsp_valid;
    logic [DATA_WIDTH-1:0] i_rsp_rdata;
    logic                  i_rsp_err;

    modport master (
        output o_req_valid, o_req_addr, o_req_we, o_req_be, o_req_wdata,
        input  i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err
    );

    modport slave (
        input  o_req_valid, o_req_addr, o_req_we, o_req_be, o_req_wdata,
        output i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err
    );
endinterface

// File: rtl/load_align.sv
// Combinational load extraction: shifts the addressed lane down to bit 0,
// truncates to the access size and sign- or zero-extends (func3[2]=1 -> zero).
module load_align
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [2:0]            i_offset,
    input  logic [2:0]            i_func3,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] shifted;
    logic                  sign_bit;

    always_comb begin
        shifted  = i_rdata >> {i_offset, 3'b000};
        sign_bit = 1'b0;
        o_data   = shifted;
        case (i_func3[1:0])
            SIZE_B: begin
                sign_bit = shifted[7] & ~i_func3[2];
                o_data   = {{(DATA_WIDTH-8){sign_bit}}, shifted[7:0]};
            end
            SIZE_H: begin
                sign_bit = shifted[15] & ~i_func3[2];
                o_data   = {{(DATA_WIDTH-16){sign_bit}}, shifted[15:0]};
            end
            SIZE_W: begin
                sign_bit = shifted[31] & ~i_func3[2];
                o_data   = {{(DATA_WIDTH-32){sign_bit}}, shifted[31:0]};
            end
            default: o_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns one memory instruction into a bus request, waits for
// the response (with timeout) and reports data or a fault for one cycle.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing them.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_arstn,
    input  logic                  i_mem_access,
    input  logic                  i_mem_we,
    input  logic [2:0]            i_func3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    output logic                  o_stall_mem,
    mem_access_unit_if.master     bus,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_load_data,
    output logic                  o_fault,
    output logic [3:0]            o_cause
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  fault_q, fault_d;
    logic [3:0]            cause_q, cause_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            func3_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  latch_en;
    logic                  req_valid;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] aligned_data;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign misaligned = (i_addr[2:0] & align_mask(i_func3[1:0])) != 3'b000;
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fault_d     = fault_q;
        cause_d     = cause_q;
        rdata_d     = rdata_q;
        latch_en    = 1'b0;
        o_stall_mem = 1'b0;
        req_valid   = 1'b0;
        o_done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_mem_access) begin
                    o_stall_mem = 1'b1;
                    latch_en    = 1'b1;
                    fault_d     = 1'b0;
                    cause_d     = 4'd0;
                    rdata_d     = '0;
                    if (misaligned) begin
                        fault_d = 1'b1;
                        cause_d = i_mem_we ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                o_stall_mem = 1'b1;
                req_valid   = 1'b1;
                if (bus.i_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                o_stall_mem = 1'b1;
                if (bus.i_rsp_valid) begin
                    rdata_d = bus.i_rsp_rdata;
                    if (bus.i_rsp_err) begin
                        fault_d = 1'b1;
                        cause_d = we_q ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    cause_d = we_q ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Access payload is captured once in IDLE so the request stays stable while stalled.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
            cause_q <= 4'd0;
            rdata_q <= '0;
            addr_q  <= '0;
            func3_q <= 3'd0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            rdata_q <= rdata_d;
            if (latch_en) begin
                addr_q  <= i_addr;
                func3_q <= i_func3;
                we_q    <= i_mem_we;
                wdata_q <= i_write_data;
            end
        end
    end

    // Byte enables are computed in 8 bits, so lanes past the doubleword fall off.
    assign bus.o_req_valid = req_valid;
    assign bus.o_req_addr  = {addr_q[ADDR_WIDTH-1:3], 3'b000};
    assign bus.o_req_we    = we_q;
    assign bus.o_req_be    = size_mask(func3_q[1:0]) << addr_q[2:0];
    assign bus.o_req_wdata = wdata_q << {addr_q[2:0], 3'b000};

    load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .i_rdata (rdata_q),
        .i_offset(addr_q[2:0]),
        .i_func3 (func3_q),
        .o_data  (aligned_data)
    );

    assign o_load_data = (state_q == ST_DONE && !fault_q && !we_q) ? aligned_data : '0;
    assign o_fault     = (state_q == ST_DONE) && fault_q;
    assign o_cause     = (state_q == ST_DONE) ? cause_q : 4'd0;

endmodule
